// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the 8-bit datapath: owns the PC and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB with Moore control outputs.
module multicycle_ctrl #(
    parameter logic [7:0]  PC_RESET    = 8'h00,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic        mem_ready,
    output logic [7:0]  pc,
    output logic        ir_load,
    output logic [2:0]  alu_opcode,
    output logic        sourceALU,
    output logic        regDestination,
    output logic        memory_read,
    output logic        memoryWrite,
    output logic        memory_to_register,
    output logic        register_write,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
    } state_t;

    localparam logic [2:0] OP_LW        = 3'b101;
    localparam logic [2:0] OP_SW        = 3'b110;
    localparam logic [2:0] OP_HALT      = 3'b111;
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [7:0]  wait_cnt;
    logic        retire, pc_step, restart;
    logic        alu_phase;

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        pc_step   = 1'b0;
        restart   = 1'b0;
        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    restart   = 1'b1;
                end
            end
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                // Decision uses the live opcode, which is being latched this cycle
                if (opcode == OP_HALT) begin
                    state_nxt = S_HALTED;
                    retire    = 1'b1;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC:   state_nxt = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                        pc_step   = 1'b1;
                    end
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
                pc_step   = 1'b1;
            end
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= PC_RESET;
            instr_count <= 16'h0000;
            wait_cnt    <= 8'h00;
            op_q        <= 3'b000;
        end else begin
            state <= state_nxt;
            if (restart)
                pc <= PC_RESET;
            else if (pc_step)
                pc <= pc + 8'd1;
            if (retire && instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
            if (state == S_DECODE)
                op_q <= opcode;
            // Clearing in EXEC restarts the count on every MEM entry
            if (state == S_EXEC)
                wait_cnt <= 8'h00;
            else if (state == S_MEM && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // ALU select and B-operand source stay stable until write-back completes
    assign alu_phase = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_comb begin
        ir_load            = (state == S_FETCH);
        alu_opcode         = 3'b000;
        sourceALU          = 1'b0;
        regDestination     = 1'b0;
        memory_read        = 1'b0;
        memoryWrite        = 1'b0;
        memory_to_register = 1'b0;
        register_write     = 1'b0;
        if (alu_phase) begin
            alu_opcode = op_q[2] ? 3'b000 : op_q;
            sourceALU  = op_q[2];
        end
        if (state == S_MEM) begin
            memory_read = (op_q == OP_LW);
            memoryWrite = (op_q == OP_SW);
        end
        if (state == S_WB) begin
            register_write     = 1'b1;
            regDestination     = ~op_q[2];
            memory_to_register = (op_q == OP_LW);
        end
        busy   = !(state == S_IDLE || state == S_HALTED || state == S_FAULT);
        halted = (state == S_HALTED);
        fault  = (state == S_FAULT);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected
// outputs, a monitor pops and compares them on each falling edge.
module tb_multicycle_ctrl;

    logic        clk, rst_n, start, mem_ready;
    logic [2:0]  opcode;
    logic [7:0]  pc;
    logic        ir_load, sourceALU, regDestination, memory_read, memoryWrite;
    logic        memory_to_register, register_write, busy, halted, fault;
    logic [2:0]  alu_opcode;
    logic [15:0] instr_count;
    logic [12:0] ctl_now;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .mem_ready(mem_ready),
        .pc(pc), .ir_load(ir_load), .alu_opcode(alu_opcode), .sourceALU(sourceALU),
        .regDestination(regDestination), .memory_read(memory_read), .memoryWrite(memoryWrite),
        .memory_to_register(memory_to_register), .register_write(register_write),
        .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    // {ir_load, alu_opcode[2:0], sourceALU, regDestination, memory_read,
    //  memoryWrite, memory_to_register, register_write, busy, halted, fault}
    assign ctl_now = {ir_load, alu_opcode, sourceALU, regDestination, memory_read,
                      memoryWrite, memory_to_register, register_write, busy, halted, fault};

    localparam logic [12:0] C_IDLE    = 13'b0_000_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] C_FETCH   = 13'b1_000_0_0_0_0_0_0_1_0_0;
    localparam logic [12:0] C_DEC     = 13'b0_000_0_0_0_0_0_0_1_0_0;
    localparam logic [12:0] C_EXEC_R  = 13'b0_000_0_0_0_0_0_0_1_0_0;
    localparam logic [12:0] C_WB_R    = 13'b0_000_0_1_0_0_0_1_1_0_0;
    localparam logic [12:0] C_EXEC_I  = 13'b0_000_1_0_0_0_0_0_1_0_0;
    localparam logic [12:0] C_WB_ADDI = 13'b0_000_1_0_0_0_0_1_1_0_0;
    localparam logic [12:0] C_MEM_LW  = 13'b0_000_1_0_1_0_0_0_1_0_0;
    localparam logic [12:0] C_WB_LW   = 13'b0_000_1_0_0_0_1_1_1_0_0;
    localparam logic [12:0] C_MEM_SW  = 13'b0_000_1_0_0_1_0_0_1_0_0;
    localparam logic [12:0] C_HALTED  = 13'b0_000_0_0_0_0_0_0_0_1_0;
    localparam logic [12:0] C_FAULT   = 13'b0_000_0_0_0_0_0_0_0_0_1;

    typedef struct {
        string       tag;
        logic [12:0] ctl;
        logic [7:0]  pcv;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    event chk_now;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string what, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", what, got, want);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or chk_now);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, " ctl"}, {3'b000, ctl_now}, {3'b000, e.ctl});
                check({e.tag, " pc"}, {8'h00, pc}, {8'h00, e.pcv});
                check({e.tag, " instr_count"}, instr_count, e.cnt);
            end
        end
    end

    task automatic push(input string tag, input logic [12:0] c, input logic [7:0] p, input logic [15:0] n);
        exp_t e;
        e.tag = tag; e.ctl = c; e.pcv = p; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic step(input string tag, input logic [12:0] c, input logic [7:0] p, input logic [15:0] n);
        @(posedge clk);
        #1;
        push(tag, c, p, n);
    endtask

    // Entered with the DUT in FETCH at pcv; leaves it in FETCH at pcv+1
    task automatic run_r(input logic [2:0] op, input logic [7:0] pcv, input logic [15:0] n);
        logic [12:0] sel;
        sel = {1'b0, op, 9'b0};
        opcode = op;
        step("r_decode", C_DEC, pcv, n);
        step("r_exec", C_EXEC_R | sel, pcv, n);
        step("r_wb", C_WB_R | sel, pcv, n);
        step("r_fetch", C_FETCH, pcv + 8'd1, n + 16'd1);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push(tag, C_IDLE, 8'h00, 16'h0000);
        ->chk_now;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0]  pcv;
        logic [15:0] cnt;
        start = 1'b0; opcode = 3'b000; mem_ready = 1'b0; rst_n = 1'b0;
        #1;
        push("reset", C_IDLE, 8'h00, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step("idle_hold", C_IDLE, 8'h00, 16'h0000);

        // ADD from IDLE
        start = 1'b1;
        step("fetch0", C_FETCH, 8'h00, 16'h0000);
        start = 1'b0;
        run_r(3'b000, 8'h00, 16'h0000);

        // LW with mem_ready on the third MEM cycle
        opcode = 3'b101;
        step("lw_decode", C_DEC, 8'h01, 16'h0001);
        step("lw_exec", C_EXEC_I, 8'h01, 16'h0001);
        step("lw_mem1", C_MEM_LW, 8'h01, 16'h0001);
        step("lw_mem2", C_MEM_LW, 8'h01, 16'h0001);
        step("lw_mem3", C_MEM_LW, 8'h01, 16'h0001);
        mem_ready = 1'b1;
        step("lw_wb", C_WB_LW, 8'h01, 16'h0001);
        mem_ready = 1'b0;
        step("lw_fetch", C_FETCH, 8'h02, 16'h0002);

        // SW, memory ready on entry, start held high while busy
        opcode = 3'b110; mem_ready = 1'b1; start = 1'b1;
        step("sw_decode", C_DEC, 8'h02, 16'h0002);
        step("sw_exec", C_EXEC_I, 8'h02, 16'h0002);
        step("sw_mem", C_MEM_SW, 8'h02, 16'h0002);
        step("sw_fetch", C_FETCH, 8'h03, 16'h0003);
        mem_ready = 1'b0; start = 1'b0;

        // Walk pc up to FF cycling through the R-type ALU selects
        pcv = 8'h03; cnt = 16'h0003;
        for (int i = 0; i < 252; i++) begin
            run_r(3'(i % 4), pcv, cnt);
            pcv = pcv + 8'd1; cnt = cnt + 16'd1;
        end

        // ADDI at pc FF wraps to 00
        opcode = 3'b100;
        step("addi_decode", C_DEC, 8'hFF, 16'd255);
        step("addi_exec", C_EXEC_I, 8'hFF, 16'd255);
        step("addi_wb", C_WB_ADDI, 8'hFF, 16'd255);
        step("addi_fetch", C_FETCH, 8'h00, 16'd256);
        run_r(3'b000, 8'h00, 16'd256);

        // HALT at pc 01, then restart from PC_RESET
        opcode = 3'b111;
        step("halt_decode", C_DEC, 8'h01, 16'd257);
        step("halted", C_HALTED, 8'h01, 16'd258);
        step("halted_hold", C_HALTED, 8'h01, 16'd258);
        start = 1'b1;
        step("restart_fetch", C_FETCH, 8'h00, 16'd258);
        start = 1'b0;
        run_r(3'b001, 8'h00, 16'd258);

        // SW with mem_ready stuck low times out into FAULT
        opcode = 3'b110;
        step("swto_decode", C_DEC, 8'h01, 16'd259);
        step("swto_exec", C_EXEC_I, 8'h01, 16'd259);
        for (int i = 0; i < 15; i++)
            step("swto_mem", C_MEM_SW, 8'h01, 16'd259);
        step("fault", C_FAULT, 8'h01, 16'd259);
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            step("fault_sticky", C_FAULT, 8'h01, 16'd259);
        end
        start = 1'b0;
        async_reset("fault_reset");
        step("fault_reset_idle", C_IDLE, 8'h00, 16'h0000);
        rst_n = 1'b1;

        // Reset asserted during write-back of an ADD
        start = 1'b1;
        step("abort_fetch", C_FETCH, 8'h00, 16'h0000);
        start = 1'b0; opcode = 3'b000;
        step("abort_decode", C_DEC, 8'h00, 16'h0000);
        step("abort_exec", C_EXEC_R, 8'h00, 16'h0000);
        step("abort_wb", C_WB_R, 8'h00, 16'h0000);
        async_reset("wb_reset");
        step("wb_reset_idle", C_IDLE, 8'h00, 16'h0000);
        rst_n = 1'b1;
        step("post_reset_idle", C_IDLE, 8'h00, 16'h0000);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 16'(sb.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
